lcd_hd44780_seq: RTL and testbench
==================================

Name: lcd_hd44780_seq

Overview:
- Sequencer for the HD44780-class character LCD port (lcd_data/lcd_e/lcd_rs/lcd_rw) behind the AXI-Lite LCD top level.
- After reset it runs the mandatory power-on initialisation, then accepts one command or data byte at a time from the register side over valid/ready.
- For each byte it generates the RS setup, E pulse, hold and execution-wait timing, so software never times the bus.

Parameters:
- T_POWERUP, 3000000, cycles from reset release to first init write (15 ms @ 200 MHz)
- T_SETUP, 12, cycles RS/data stable before E rises
- T_EPW, 60, cycles E held high
- T_HOLD, 4, cycles RS/data held after E falls
- T_CMD, 8000, execution wait for normal commands/data (40 us)
- T_LONG, 328000, execution wait for clear/home (1.64 ms)
- T_INIT1, 820000, wait after first 0x38 (4.1 ms)
- T_INIT2, 20000, wait after second 0x38 (100 us)
- CNT_W, 24, delay counter width; must hold the largest T_*

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  request present
- cmd_ready  out  1  sequencer accepts request this cycle
- cmd_rs  in  1  0 = instruction, 1 = data
- cmd_data  in  8  byte to write
- init_done  out  1  power-on sequence complete (sticky until reset)
- busy  out  1  sequencer not in IDLE
- lcd_data  out  8  LCD DB7..DB0
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write, tied 0 (write-only)

Behaviour:
- Reset values (async, immediate):
  - lcd_data=0x00, lcd_e=0, lcd_rs=0, lcd_rw=0
  - init_done=0, busy=1, cmd_ready=0
  - state=PWR_WAIT, counter loaded with T_POWERUP
- Every phase lasts max(T,1) cycles; a parameter of 0 is treated as 1.
- States:
  - PWR_WAIT → INIT_LOAD
  - INIT_LOAD: fetches init ROM entry idx, latches rs=0 and the byte → SETUP
  - SETUP (lcd_e=0) → E_HIGH (lcd_e=1) → HOLD (lcd_e=0) → EXEC_WAIT
  - EXEC_WAIT: if in init and idx<6 → idx++, INIT_LOAD; otherwise → IDLE
- Init ROM, byte/wait pairs in order:
  - 0x38/T_INIT1, 0x38/T_INIT2, 0x38/T_CMD, 0x38/T_CMD
  - 0x0C/T_CMD, 0x01/T_LONG, 0x06/T_CMD
- init_done is set on the transition EXEC_WAIT→IDLE after ROM entry 6.
- cmd_ready = (state==IDLE) && init_done, decoded from registered state. Requests during init are not accepted; they stay pending.
- Accept on cmd_valid&&cmd_ready at edge k:
  - lcd_rs=cmd_rs and lcd_data=cmd_data are valid from k+1.
  - State goes to SETUP.
- Wait selection for host commands:
  - T_LONG when cmd_rs=0 and cmd_data ∈ {0x01,0x02,0x03}.
  - T_CMD otherwise, including 0x00.
- Timing of an accepted request:
  - lcd_e rises T_SETUP cycles after acceptance and stays high exactly T_EPW cycles.
  - lcd_rs/lcd_data are unchanged from SETUP through EXEC_WAIT and retained in IDLE until the next accept.
  - busy is high from k+1 through the last EXEC_WAIT cycle.
  - cmd_ready returns high the cycle after, so back-to-back spacing = T_SETUP+T_EPW+T_HOLD+Twait+1 cycles.
- cmd_rs/cmd_data are sampled only at acceptance; later changes are ignored.
- Reset mid-operation (including with lcd_e high): lcd_e drops immediately and the full init sequence reruns. No partial resume.
- lcd_rw is constant 0; no busy-flag polling.

Decomposition:
- Package lcd_pkg:
  - state encoding
  - init ROM bytes and wait-select codes
  - command constants (CLEAR=0x01, HOME=0x02, FUNC_8BIT_2L=0x38, DISP_ON=0x0C, ENTRY_INC=0x06)
- Sub-module lcd_delay_cnt:
  - inputs: load, load value; output: done
  - CNT_W-bit down-counter, saturates at done
  - one instance shared by all phases

Test Plan (T_POWERUP=50, T_SETUP=2, T_EPW=4, T_HOLD=1, T_CMD=10, T_LONG=40, T_INIT1=30, T_INIT2=20):
- Reset release, cmd_valid=0 → seven E pulses, each 4 cycles wide, with lcd_data 0x38,0x38,0x38,0x38,0x0C,0x01,0x06 and lcd_rs=0. Gaps after pulses follow 30/20/10/10/10/40/10 waits. Then init_done=1 and cmd_ready=1.
- cmd_valid held high with rs=1, data=0x41 from reset → not accepted before init_done; accepted the first cycle cmd_ready=1. lcd_rs=1, lcd_data=0x41, lcd_e high on cycles k+3..k+6.
- Back-to-back data 0x48, 0x49 → accept edges exactly 2+4+1+10+1=18 cycles apart.
- Command rs=0, data=0x01 → next accept 2+4+1+40+1=48 cycles later. Command rs=0, data=0x80 → 18 cycles.
- Assert sys_rst while lcd_e=1 → lcd_e=0, busy=1, init_done=0 immediately (no clock edge). After release, the full init repeats.
- Toggle cmd_data during SETUP/E_HIGH → lcd_data stays at the accepted value. lcd_rw=0 throughout all tests.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 sequencer: FSM states, wait-select codes,
// LCD command bytes and the power-on initialisation ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_LOAD,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_EXEC_WAIT,
        ST_IDLE
    } state_t;

    typedef enum logic [1:0] {
        WAIT_CMD,
        WAIT_LONG,
        WAIT_INIT1,
        WAIT_INIT2
    } wait_sel_t;

    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT     = 8'h03;
    localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;

    localparam logic [2:0] INIT_LAST = 3'd6;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: return CMD_FUNC_8BIT_2L;
            3'd4:                   return CMD_DISP_ON;
            3'd5:                   return CMD_CLEAR;
            3'd6:                   return CMD_ENTRY_INC;
            default:                return 8'h00;
        endcase
    endfunction

    function automatic wait_sel_t init_wait(input logic [2:0] idx);
        case (idx)
            3'd0:    return WAIT_INIT1;
            3'd1:    return WAIT_INIT2;
            3'd5:    return WAIT_LONG;
            default: return WAIT_CMD;
        endcase
    endfunction

    // Clear display and both return-home encodings need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Shared phase timer: loading N makes done assert on the N-th cycle of the phase
// (N of 0 behaves as 1); the count then holds at zero.
module lcd_delay_cnt #(
    parameter int CNT_W   = 24,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'((RST_VAL > 1) ? RST_VAL - 1 : 0);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_CNT;
        end else if (load) begin
            cnt <= (load_val == '0) ? '0 : load_val - CNT_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_hd44780_seq.sv
// HD44780 write sequencer: runs the power-on init ROM, then writes one host
// command/data byte at a time with setup, E pulse, hold and execution wait.
module lcd_hd44780_seq
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = 3000000,
    parameter int T_SETUP   = 12,
    parameter int T_EPW     = 60,
    parameter int T_HOLD    = 4,
    parameter int T_CMD     = 8000,
    parameter int T_LONG    = 328000,
    parameter int T_INIT1   = 820000,
    parameter int T_INIT2   = 20000,
    parameter int CNT_W     = 24
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] L_EPW   = CNT_W'(T_EPW);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(T_CMD);
    localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(T_LONG);
    localparam logic [CNT_W-1:0] L_INIT1 = CNT_W'(T_INIT1);
    localparam logic [CNT_W-1:0] L_INIT2 = CNT_W'(T_INIT2);

    state_t           state;
    state_t           state_next;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] exec_len;
    logic             cnt_done;
    logic [2:0]       init_idx;
    wait_sel_t        wait_sel;
    logic             accept;

    assign cmd_ready = (state == ST_IDLE) && init_done;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);
    assign lcd_rw    = 1'b0;

    lcd_delay_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (T_POWERUP)
    ) u_delay (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        exec_len = L_CMD;
        case (wait_sel)
            WAIT_LONG:  exec_len = L_LONG;
            WAIT_INIT1: exec_len = L_INIT1;
            WAIT_INIT2: exec_len = L_INIT2;
            default:    exec_len = L_CMD;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_PWR_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Every phase change reloads the shared timer with the length of the phase being entered.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        case (state)
            ST_PWR_WAIT: begin
                if (cnt_done) begin
                    state_next = ST_INIT_LOAD;
                end
            end
            ST_INIT_LOAD: begin
                state_next = ST_SETUP;
                cnt_load   = 1'b1;
                cnt_val    = L_SETUP;
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    state_next = ST_E_HIGH;
                    cnt_load   = 1'b1;
                    cnt_val    = L_EPW;
                end
            end
            ST_E_HIGH: begin
                if (cnt_done) begin
                    state_next = ST_HOLD;
                    cnt_load   = 1'b1;
                    cnt_val    = L_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    state_next = ST_EXEC_WAIT;
                    cnt_load   = 1'b1;
                    cnt_val    = exec_len;
                end
            end
            ST_EXEC_WAIT: begin
                if (cnt_done) begin
                    if (!init_done && init_idx != INIT_LAST) begin
                        state_next = ST_INIT_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SETUP;
                    cnt_load   = 1'b1;
                    cnt_val    = L_SETUP;
                end
            end
            default: begin
                state_next = ST_PWR_WAIT;
            end
        endcase
    end

    // lcd_e is registered from the next state so the strobe never glitches on state decode.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            init_done <= 1'b0;
            init_idx  <= 3'd0;
            wait_sel  <= WAIT_CMD;
        end else begin
            lcd_e <= (state_next == ST_E_HIGH);
            if (state == ST_INIT_LOAD) begin
                lcd_rs   <= 1'b0;
                lcd_data <= init_byte(init_idx);
                wait_sel <= init_wait(init_idx);
            end
            if (accept) begin
                lcd_rs   <= cmd_rs;
                lcd_data <= cmd_data;
                wait_sel <= is_long_cmd(cmd_rs, cmd_data) ? WAIT_LONG : WAIT_CMD;
            end
            if (state == ST_EXEC_WAIT && cnt_done && !init_done) begin
                if (init_idx == INIT_LAST) begin
                    init_done <= 1'b1;
                end else begin
                    init_idx <= init_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_seq.sv
// Self-checking bench for lcd_hd44780_seq: E-pulse scoreboard, handshake
// spacing table, reset-during-strobe and input-stability sequences.
module tb_lcd_hd44780_seq;

    localparam int T_POWERUP = 50;
    localparam int T_SETUP   = 2;
    localparam int T_EPW     = 4;
    localparam int T_HOLD    = 1;
    localparam int T_CMD     = 10;
    localparam int T_LONG    = 40;
    localparam int T_INIT1   = 30;
    localparam int T_INIT2   = 20;
    localparam int PHASES    = T_SETUP + T_EPW + T_HOLD;
    // Power-up wait, then seven ROM writes each of INIT_LOAD + phases + wait.
    localparam int INIT_TOTAL = T_POWERUP + 7 * (1 + PHASES)
                              + T_INIT1 + T_INIT2 + T_CMD + T_CMD + T_CMD + T_LONG + T_CMD;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       init_done;
    logic       busy;
    logic [7:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;

    lcd_hd44780_seq #(
        .T_POWERUP (T_POWERUP),
        .T_SETUP   (T_SETUP),
        .T_EPW     (T_EPW),
        .T_HOLD    (T_HOLD),
        .T_CMD     (T_CMD),
        .T_LONG    (T_LONG),
        .T_INIT1   (T_INIT1),
        .T_INIT2   (T_INIT2),
        .CNT_W     (24)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .init_done (init_done),
        .busy      (busy),
        .lcd_data  (lcd_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } exp_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         wait_cyc;
    } vec_t;

    exp_t sb[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushInit();
        int         w[7];
        logic [7:0] b[7];
        w = '{T_INIT1, T_INIT2, T_CMD, T_CMD, T_CMD, T_LONG, T_CMD};
        b = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 7; i++) begin
            exp_t e;
            e.rs   = 1'b0;
            e.data = b[i];
            e.gap  = (i == 0) ? -1 : w[i-1] + T_HOLD + 1 + T_SETUP;
            sb.push_back(e);
        end
    endtask

    // Monitor: every E pulse is matched against the scoreboard and measured.
    bit         e_prev = 1'b0;
    int         e_width = 0;
    int         fall_cyc = 0;
    int         rise_cyc = 0;
    logic [7:0] rise_data;
    logic       rise_rs;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            e_prev  = 1'b0;
            e_width = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                rise_cyc  = cyc;
                rise_data = lcd_data;
                rise_rs   = lcd_rs;
                e_width   = 1;
                checkOutput("rw_low", {31'd0, lcd_rw}, 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", {24'd0, lcd_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("pulse_data", {24'd0, lcd_data}, {24'd0, e.data});
                    checkOutput("pulse_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
                    if (e.gap >= 0) begin
                        checkOutput("pulse_gap", cyc - fall_cyc, e.gap);
                    end
                end
            end else if (lcd_e) begin
                e_width++;
            end else if (e_prev) begin
                checkOutput("pulse_width", e_width, T_EPW);
                checkOutput("pulse_data_stable", {24'd0, lcd_data}, {24'd0, rise_data});
                checkOutput("pulse_rs_stable", {31'd0, lcd_rs}, {31'd0, rise_rs});
                fall_cyc = cyc;
            end
            e_prev = lcd_e;
        end
    end

    // Called at a negedge; returns at the negedge where cmd_ready is seen high.
    task automatic waitReady(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic rs, input logic [7:0] data, output int acc);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = data;
        e.rs   = rs;
        e.data = data;
        e.gap  = -1;
        sb.push_back(e);
        waitReady(600);
        acc = cyc;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t tbl[8];
    int   c0;
    int   acc;
    int   prev_acc;
    bit   seen_e;

    initial begin
        tbl[0] = '{1'b1, 8'h48, T_CMD};
        tbl[1] = '{1'b1, 8'h49, T_CMD};
        tbl[2] = '{1'b0, 8'h01, T_LONG};
        tbl[3] = '{1'b0, 8'h80, T_CMD};
        tbl[4] = '{1'b0, 8'h02, T_LONG};
        tbl[5] = '{1'b0, 8'h03, T_LONG};
        tbl[6] = '{1'b0, 8'h00, T_CMD};
        tbl[7] = '{1'b1, 8'h01, T_CMD};

        // Reset state, with a data request already pending.
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h41;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
        checkOutput("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
        checkOutput("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        checkOutput("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd1);
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        pushInit();
        begin
            exp_t e;
            e.rs = 1'b1; e.data = 8'h41; e.gap = -1;
            sb.push_back(e);
        end
        sys_rst = 1'b0;
        c0 = cyc;

        // Pending request is accepted on the first ready cycle after init.
        waitReady(1000);
        acc = cyc;
        checkOutput("init_ready_cycle", acc - c0, INIT_TOTAL);
        checkOutput("init_done_set", {31'd0, init_done}, 32'd1);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        for (int off = 1; off <= PHASES; off++) begin
            cmd_data = 8'($urandom);
            cmd_rs   = 1'($urandom);
            checkOutput("hold_data", {24'd0, lcd_data}, 32'h41);
            checkOutput("hold_rs", {31'd0, lcd_rs}, 32'd1);
            checkOutput("e_timing", {31'd0, lcd_e},
                        (off > T_SETUP && off <= T_SETUP + T_EPW) ? 32'd1 : 32'd0);
            checkOutput("busy_cmd", {31'd0, busy}, 32'd1);
            @(negedge sys_clk);
        end
        waitReady(200);
        checkOutput("first_spacing", cyc - acc, PHASES + T_CMD + 1);
        checkOutput("idle_data_kept", {24'd0, lcd_data}, 32'h41);
        checkOutput("idle_rs_kept", {31'd0, lcd_rs}, 32'd1);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // Back-to-back requests: spacing follows the wait class of the previous byte.
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].rs, tbl[i].data, acc);
            if (i > 0) begin
                checkOutput("b2b_spacing", acc - prev_acc, PHASES + tbl[i-1].wait_cyc + 1);
            end
            prev_acc = acc;
        end
        waitReady(200);
        checkOutput("last_spacing", cyc - prev_acc, PHASES + tbl[7].wait_cyc + 1);
        checkOutput("sb_drained", sb.size(), 32'd0);

        // Reset while E is high: outputs drop without a clock edge, init reruns.
        applyStimulus(1'b1, 8'h55, acc);
        seen_e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lcd_e) begin
                seen_e = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        checkOutput("e_seen_before_reset", {31'd0, seen_e}, 32'd1);
        #1;
        sys_rst = 1'b1;
        #1;
        checkOutput("async_rst_e", {31'd0, lcd_e}, 32'd0);
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd1);
        checkOutput("async_rst_init_done", {31'd0, init_done}, 32'd0);
        checkOutput("async_rst_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (3) @(negedge sys_clk);
        sb.delete();
        pushInit();
        sys_rst = 1'b0;
        c0 = cyc;
        waitReady(1000);
        checkOutput("reinit_ready_cycle", cyc - c0, INIT_TOTAL);
        checkOutput("reinit_done", {31'd0, init_done}, 32'd1);
        checkOutput("reinit_sb_drained", sb.size(), 32'd0);
        checkOutput("final_rw", {31'd0, lcd_rw}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
